mdu_unit: RTL and testbench
===========================

MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, sets the busy duration of mult/multu in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, sets the busy duration of div/divu in cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle pulse from E stage launching the op on MDUop.
REQ-006 MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
REQ-007 A  input  32  forwarded rs value (multiplicand, dividend, or mthi/mtlo data).
REQ-008 B  input  32  forwarded rt value (multiplier, divisor).
REQ-009 busy  output  1  high while a mult/div is in progress.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.
REQ-012 out  output  32  read data for mfhi/mflo, consumed by E-stage result mux.

Function
REQ-013 Two states, IDLE and BUSY, plus a cycle counter and internal pending-result registers.
REQ-014 In IDLE, start=1 with MDUop 1-4 SHALL capture A, B and op, load the counter, and enter BUSY on the next edge.
REQ-015 busy SHALL read 1 from the cycle after the start edge for exactly MULT_CYCLES (op 1-2) or DIV_CYCLES (op 3-4) cycles, then 0.
REQ-016 The computed result SHALL be written to HI/LO on the edge that ends the last busy cycle, with a return to IDLE on that same edge.
REQ-017 mult: {HI,LO} = signed 64-bit product; multu: unsigned 64-bit product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; divu: unsigned quotient and remainder.
REQ-019 div with -2^31 / -1 SHALL yield LO=0x80000000, HI=0.
REQ-020 A divisor of 0 (div/divu) SHALL run the full DIV_CYCLES with busy asserted and leave HI/LO unchanged.
REQ-021 start while busy=1 SHALL be ignored; the hazard unit guarantees no such start, and the block must not corrupt the running op.
REQ-022 start with MDUop 0, 5, 6 or 9-15 SHALL change no state.
REQ-023 mthi (7) / mtlo (8) with start=1 in IDLE SHALL write A to HI / LO on that edge; busy stays 0.
REQ-024 mthi/mtlo arriving during BUSY SHALL be ignored.
REQ-025 out SHALL be combinational: HI when MDUop=5, LO when MDUop=6, else 0; it reflects the current register value and is independent of busy.
REQ-026 Operands SHALL be sampled only at the start edge; later changes on A/B have no effect on the result.
REQ-027 Back-to-back ops: start is accepted in the first cycle where busy=0 after a completion, giving a minimum gap of 0 idle cycles.
REQ-028 The stall condition seen by the hazard unit is (start && MDUop in 1-4) || busy; this block only provides busy.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, counter 0, busy 0, HI 0, LO 0, and pending result 0, independent of clk.
REQ-030 Reset during BUSY SHALL abort the op; no result is ever written after reset releases.
REQ-031 After release, the first rising edge with start=1 behaves as in IDLE.

Verification
REQ-032 mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; mfhi gives out=0xFFFFFFFF.
REQ-033 multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-035 mthi A=0x1234 then div B=0 -> HI stays 0x1234 and LO stays 0 after 10 busy cycles; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 mult start, reset=0 at busy cycle 3 -> busy=0, HI=LO=0 immediately; no write after release.
REQ-037 start mult during busy of div, and mtlo during busy -> ignored; the div result is correct and LO is not overwritten by the mtlo.

Source files
------------

// File: rtl/mdu_unit_if.sv
// mdu_unit_if
// Purpose : bundles the E-stage <-> multiply/divide unit signals.
// Ports   : start  - one-cycle launch pulse from the E stage
//           MDUop  - operation code (mult/multu/div/divu/mfhi/mflo/mthi/mtlo)
//           A, B   - forwarded rs / rt operands
//           busy   - high while a mult/div is in progress
//           HI, LO - architectural HI/LO registers
//           out    - mfhi/mflo read data for the E-stage result mux
interface mdu_unit_if;
  logic        start;
  logic [3:0]  MDUop;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] out;

  // E stage side: issues operations and reads results
  modport master (
    output start, MDUop, A, B,
    input  busy, HI, LO, out
  );

  // MDU side: accepts operations and presents results
  modport slave (
    input  start, MDUop, A, B,
    output busy, HI, LO, out
  );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit
// Purpose : multi-cycle multiply/divide unit holding the HI/LO registers.
//           mult/multu/div/divu are launched by a start pulse, keep busy high
//           for a fixed number of cycles and then commit to HI/LO. mthi/mtlo
//           write immediately; mfhi/mflo are served combinationally on out.
// Ports   : clk   - clock, rising edge active
//           reset - asynchronous reset, active low
//           bus   - mdu_unit_if slave modport (start/MDUop/A/B in,
//                   busy/HI/LO/out out)
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        pend_hi, pend_lo;
  logic               pend_wr;

  logic               accept_op, finish_op, write_hi, write_lo;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        mag_a, mag_b, safe_mag_b, safe_b;
  logic [31:0]        uq, ur, sq, sr, udq, udr;
  logic               div_zero;
  logic [31:0]        calc_hi, calc_lo;
  logic               calc_wr;
  logic [CNT_W-1:0]   calc_cycles;

  // Result of the operation on the bus, computed from the operands present
  // at the start edge and parked in the pending registers until the last
  // busy cycle. The signed product is the low 64 bits of the product of the
  // sign-extended operands. Signed division works on magnitudes and then
  // fixes up signs; -2^31 / -1 falls out naturally as 0x80000000 rem 0.
  // A zero divisor is replaced by 1 only to keep the dividers defined; the
  // result is discarded through calc_wr.
  always_comb begin
    prod_s      = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u      = {32'd0, bus.A} * {32'd0, bus.B};
    div_zero    = (bus.B == 32'd0);
    mag_a       = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    mag_b       = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
    safe_mag_b  = div_zero ? 32'd1 : mag_b;
    safe_b      = div_zero ? 32'd1 : bus.B;
    uq          = mag_a / safe_mag_b;
    ur          = mag_a % safe_mag_b;
    sq          = (bus.A[31] ^ bus.B[31]) ? (~uq + 32'd1) : uq;
    sr          = bus.A[31] ? (~ur + 32'd1) : ur;
    udq         = bus.A / safe_b;
    udr         = bus.A % safe_b;

    calc_hi     = 32'd0;
    calc_lo     = 32'd0;
    calc_wr     = 1'b0;
    calc_cycles = CNT_W'(DIV_CYCLES - 1);
    case (bus.MDUop)
      OP_MULT: begin
        calc_hi     = prod_s[63:32];
        calc_lo     = prod_s[31:0];
        calc_wr     = 1'b1;
        calc_cycles = CNT_W'(MULT_CYCLES - 1);
      end
      OP_MULTU: begin
        calc_hi     = prod_u[63:32];
        calc_lo     = prod_u[31:0];
        calc_wr     = 1'b1;
        calc_cycles = CNT_W'(MULT_CYCLES - 1);
      end
      OP_DIV: begin
        calc_hi = sr;
        calc_lo = sq;
        calc_wr = ~div_zero;
      end
      OP_DIVU: begin
        calc_hi = udr;
        calc_lo = udq;
        calc_wr = ~div_zero;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode. Starts are only honoured in IDLE, so any
  // start seen while BUSY (including mthi/mtlo) is dropped. The counter is
  // loaded with N-1, giving exactly N busy cycles ending on count == 0.
  always_comb begin
    state_next = state;
    accept_op  = 1'b0;
    finish_op  = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.MDUop)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              accept_op  = 1'b1;
              state_next = BUSY;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (count == '0) begin
          finish_op  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter, pending result and HI/LO. Reset clears the pending result so an
  // aborted operation can never commit after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      if (accept_op) begin
        count   <= calc_cycles;
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
        pend_wr <= calc_wr;
      end else if (state == BUSY && count != '0) begin
        count <= count - CNT_W'(1);
      end

      if (finish_op && pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end

      if (write_hi) hi_q <= bus.A;
      if (write_lo) lo_q <= bus.A;
    end
  end

  // Read port for mfhi/mflo, independent of busy
  always_comb begin
    case (bus.MDUop)
      OP_MFHI: bus.out = hi_q;
      OP_MFLO: bus.out = lo_q;
      default: bus.out = 32'd0;
    endcase
  end

  assign bus.busy = (state == BUSY);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit
// Purpose : self-checking bench for mdu_unit. A table of directed vectors is
//           applied back to back, followed by hand-written sequences for
//           read-out, starts during busy, and reset in the middle of an op.
// Ports   : none (top-level bench)
module tb_mdu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_unit_if bus ();

  mdu_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[15];

  // One comparison; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Entered and left on a falling edge. Pulses start for one cycle, then
  // scrambles A/B so late operand changes would corrupt a wrong design, and
  // counts busy cycles until busy drops (bounded).
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, output int busy_cycles);
    bus.start = 1'b1;
    bus.MDUop = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
    bus.A     = ~a;
    bus.B     = ~b;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;

    vecs[0]  = '{"mult_neg1x2",    4'd1, 32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_maxx2",    4'd2, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7_2",       4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_m7_2",      4'd4, 32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC};
    vecs[4]  = '{"mtlo_0",         4'd8, 32'h00000000, 32'd0,        0,  32'h00000001, 32'h00000000};
    vecs[5]  = '{"mthi_1234",      4'd7, 32'h00001234, 32'd0,        0,  32'h00001234, 32'h00000000};
    vecs[6]  = '{"div_by_zero",    4'd3, 32'h00000005, 32'd0,        10, 32'h00001234, 32'h00000000};
    vecs[7]  = '{"div_overflow",   4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[8]  = '{"mult_7xm3",      4'd1, 32'h00000007, 32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[9]  = '{"div_7_m2",       4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{"divu_100_7",     4'd4, 32'h00000064, 32'd7,        10, 32'h00000002, 32'h0000000E};
    vecs[11] = '{"multu_2p16sq",   4'd2, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
    vecs[12] = '{"start_op0",      4'd0, 32'h0000FFFF, 32'd3,        0,  32'h00000001, 32'h00000000};
    vecs[13] = '{"start_op9",      4'd9, 32'h0000FFFF, 32'd3,        0,  32'h00000001, 32'h00000000};
    vecs[14] = '{"start_mflo",     4'd6, 32'h0000FFFF, 32'd3,        0,  32'h00000001, 32'h00000000};

    // Reset is asynchronous, so values must be cleared without a clock edge
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_hi",   bus.HI, 32'd0);
    checkOutput("reset_lo",   bus.LO, 32'd0);
    checkOutput("reset_out",  bus.out, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table: applied back to back with no idle cycles between operations
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, n);
      checkOutput({vecs[i].name, "_busy"}, 32'(n), 32'(vecs[i].exp_busy));
      checkOutput({vecs[i].name, "_hi"},   bus.HI, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo"},   bus.LO, vecs[i].exp_lo);
    end

    // Read-out port
    applyStimulus(4'd8, 32'h00000BAD, 32'd0, n);
    applyStimulus(4'd7, 32'h00000BEE, 32'd0, n);
    bus.MDUop = 4'd5; #1;
    checkOutput("out_mfhi", bus.out, 32'h00000BEE);
    bus.MDUop = 4'd6; #1;
    checkOutput("out_mflo", bus.out, 32'h00000BAD);
    bus.MDUop = 4'd7; #1;
    checkOutput("out_mthi_zero", bus.out, 32'd0);
    bus.MDUop = 4'd9; #1;
    checkOutput("out_op9_zero", bus.out, 32'd0);
    bus.MDUop = 4'd0;
    @(negedge clk);

    // Starts during busy: a mult and an mtlo arrive mid-div and must be dropped
    bus.start = 1'b1;
    bus.MDUop = 4'd3;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy === 1'b1) n++;
      bus.start = 1'b0;
      bus.MDUop = 4'd0;
      bus.A     = 32'h0;
      bus.B     = 32'h0;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.MDUop = 4'd1;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
      end else if (i == 4) begin
        bus.start = 1'b1;
        bus.MDUop = 4'd8;
        bus.A     = 32'h0000DEAD;
      end else if (i == 6) begin
        bus.MDUop = 4'd6;
        #1;
        checkOutput("out_lo_while_busy", bus.out, 32'h00000BAD);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
    checkOutput("ignore_busy_cycles", 32'(n), 32'd10);
    checkOutput("ignore_busy_done", {31'd0, bus.busy}, 32'd0);
    checkOutput("ignore_hi", bus.HI, 32'd2);
    checkOutput("ignore_lo", bus.LO, 32'd14);

    // Reset asserted in busy cycle 3 aborts the mult and nothing commits later
    bus.start = 1'b1;
    bus.MDUop = 4'd1;
    bus.A     = 32'd6;
    bus.B     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.MDUop = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_hi",   bus.HI, 32'd0);
    checkOutput("abort_lo",   bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) n++;
    end
    checkOutput("abort_no_busy", 32'(n), 32'd0);
    checkOutput("abort_hi_after", bus.HI, 32'd0);
    checkOutput("abort_lo_after", bus.LO, 32'd0);

    // First start after release behaves normally
    applyStimulus(4'd1, 32'd3, 32'd4, n);
    checkOutput("post_reset_busy", 32'(n), 32'd5);
    checkOutput("post_reset_hi", bus.HI, 32'd0);
    checkOutput("post_reset_lo", bus.LO, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
